// File: rtl/pll_reset_seq.sv
// Reset sequencer behind the PLL: qualifies a synchronized lock flag and releases a clean,
// registered active-low reset. Short lock dropouts are filtered; long ones are counted.
module pll_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_CYCLES     = 16,
  parameter int GLITCH_CYCLES      = 4,
  parameter int CNT_W              = 8
) (
  input  logic             pll_clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             clear_stat,
  output logic             rst_out_n,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [1:0]       state
);

  localparam int MAX_LR  = (LOCK_STABLE_CYCLES > RELEASE_CYCLES) ? LOCK_STABLE_CYCLES : RELEASE_CYCLES;
  localparam int MAX_CYC = (MAX_LR > GLITCH_CYCLES) ? MAX_LR : GLITCH_CYCLES;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] REL_LAST  = TW'(RELEASE_CYCLES - 1);
  localparam logic [TW-1:0] GL_LAST   = TW'(GLITCH_CYCLES - 1);
  localparam logic [TW-1:0] ONE       = TW'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             rst_out_n_q, rst_out_n_d;
  logic             lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic             lock_s;
  logic             qual_loss;

  assign lock_s = sync_q[1];

  always_comb begin
    sync_d      = {sync_q[0], pll_lock};
    state_d     = state_q;
    cnt_d       = cnt_q;
    qual_loss   = 1'b0;
    lock_lost_d = lock_lost_q;
    loss_cnt_d  = loss_cnt_q;

    case (state_q)
      WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      HOLD: begin
        // A drop here is just an unfinished qualification, not a counted loss.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == REL_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          if (GLITCH_CYCLES == 1) begin
            qual_loss = 1'b1;
          end else begin
            state_d = LOST;
            cnt_d   = ONE;
          end
        end
      end
      LOST: begin
        if (lock_s) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == GL_LAST) begin
          qual_loss = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    if (qual_loss) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end

    // Clear is applied first so a coinciding loss is still recorded.
    if (clear_stat) begin
      lock_lost_d = 1'b0;
      loss_cnt_d  = '0;
    end
    if (qual_loss) begin
      lock_lost_d = 1'b1;
      if (loss_cnt_d != {CNT_W{1'b1}}) loss_cnt_d = loss_cnt_d + 1'b1;
    end

    rst_out_n_d = (state_d == RUN) || (state_d == LOST);
  end

  always_ff @(posedge pll_clk) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      rst_out_n_q <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_out_n_q <= rst_out_n_d;
      lock_lost_q <= lock_lost_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign rst_out_n = rst_out_n_q;
  assign ready     = (state_q == RUN);
  assign lock_lost = lock_lost_q;
  assign loss_cnt  = loss_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: segment table, hand sequences and random lock traffic,
// all checked every cycle against a run-length model of the lock history.
module tb_pll_reset_seq;
  localparam int L    = 24;
  localparam int R    = 6;
  localparam int G    = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          pll_clk, rst_n, pll_lock, clear_stat;
  logic          rst_out_n, ready, lock_lost;
  logic [CW-1:0] loss_cnt;
  logic [1:0]    state;

  int n_cmp = 0;
  int n_bad = 0;

  pll_reset_seq #(
    .LOCK_STABLE_CYCLES(L), .RELEASE_CYCLES(R), .GLITCH_CYCLES(G), .CNT_W(CW)
  ) dut (
    .pll_clk(pll_clk), .rst_n(rst_n), .pll_lock(pll_lock), .clear_stat(clear_stat),
    .rst_out_n(rst_out_n), .ready(ready), .lock_lost(lock_lost),
    .loss_cnt(loss_cnt), .state(state)
  );

  initial pll_clk = 1'b0;
  always #5 pll_clk = ~pll_clk;

  // Model: lock seen through a 2-deep delay; reset is up once L+R consecutive synced-high
  // cycles accumulate, and drops after G consecutive synced-low cycles while up.
  logic m_d1 = 1'b0, m_d2 = 1'b0, m_up = 1'b0, m_lost = 1'b0;
  int   m_hi = 0, m_lo = 0, m_cnt = 0;

  task automatic model_edge(input logic r, input logic l, input logic c);
    bit loss;
    loss = 1'b0;
    if (!r) begin
      m_d1 = 0; m_d2 = 0; m_up = 0; m_lost = 0; m_hi = 0; m_lo = 0; m_cnt = 0;
      return;
    end
    if (!m_up) begin
      m_hi = m_d2 ? m_hi + 1 : 0;
      if (m_hi == L + R) begin m_up = 1; m_hi = 0; m_lo = 0; end
    end else begin
      m_lo = m_d2 ? 0 : m_lo + 1;
      if (m_lo == G) begin loss = 1; m_up = 0; m_hi = 0; m_lo = 0; end
    end
    if (c) begin m_lost = 0; m_cnt = 0; end
    if (loss) begin m_lost = 1; if (m_cnt < CMAX) m_cnt++; end
    m_d2 = m_d1;
    m_d1 = l;
  endtask

  function automatic int m_state();
    if (!m_up) return (m_hi >= L) ? 1 : 0;
    return (m_lo > 0) ? 3 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("m_state", {30'd0, state}, m_state());
    check("m_rst_out_n", {31'd0, rst_out_n}, {31'd0, m_up});
    check("m_ready", {31'd0, ready}, (m_up && m_lo == 0) ? 1 : 0);
    check("m_lock_lost", {31'd0, lock_lost}, {31'd0, m_lost});
    check("m_loss_cnt", {24'd0, loss_cnt}, m_cnt);
  endtask

  // Inputs are driven just after a falling edge; outputs sampled on the falling edge.
  task automatic step(input logic r, input logic l, input logic c);
    rst_n = r; pll_lock = l; clear_stat = c;
    @(posedge pll_clk);
    model_edge(r, l, c);
    @(negedge pll_clk);
    check_model();
  endtask

  task automatic bring_up();
    int n;
    n = 0;
    do begin step(1, 1, 0); n++; end while (!ready && n < 100);
    check("bringup_ready", {31'd0, ready}, 1);
  endtask

  typedef struct {
    logic r, l, c;
    int   n;
    int   st, ro, rd, ll, lc;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int n;
    tbl[0]  = '{1'b0, 1'b0, 1'b0,  5, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 31, 1, 0, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0,  1, 2, 1, 1, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0,  3, 3, 1, 0, 0, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0,  2, 3, 1, 0, 0, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0,  1, 2, 1, 1, 0, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 10, 0, 0, 0, 1, 1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 31, 1, 0, 0, 1, 1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0,  1, 2, 1, 1, 1, 1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1,  1, 2, 1, 1, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b0,  1, 0, 0, 0, 0, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b0,  2, 0, 0, 0, 0, 0};

    rst_n = 1'b0; pll_lock = 1'b0; clear_stat = 1'b0;

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].l, tbl[i].c);
      check($sformatf("tbl%0d_state", i), {30'd0, state}, tbl[i].st);
      check($sformatf("tbl%0d_rst_out_n", i), {31'd0, rst_out_n}, tbl[i].ro);
      check($sformatf("tbl%0d_ready", i), {31'd0, ready}, tbl[i].rd);
      check($sformatf("tbl%0d_lock_lost", i), {31'd0, lock_lost}, tbl[i].ll);
      check($sformatf("tbl%0d_loss_cnt", i), {24'd0, loss_cnt}, tbl[i].lc);
    end

    // One-cycle dropout mid-qualification restarts the full count.
    step(0, 0, 0); step(0, 0, 0);
    for (int k = 0; k < 12; k++) step(1, 1, 0);
    step(1, 0, 0);
    n = 0;
    do begin step(1, 1, 0); n++; end while (!rst_out_n && n < 200);
    check("relock_latency", n, 2 + L + R);
    check("dropout_loss_cnt", {24'd0, loss_cnt}, 0);

    // Saturation of the loss counter, then clear.
    for (int j = 0; j < 300; j++) begin
      bring_up();
      for (int k = 0; k < G + 2; k++) step(1, 0, 0);
    end
    check("sat_loss_cnt", {24'd0, loss_cnt}, CMAX);
    check("sat_lock_lost", {31'd0, lock_lost}, 1);
    step(1, 0, 1);
    check("clr_loss_cnt", {24'd0, loss_cnt}, 0);
    check("clr_lock_lost", {31'd0, lock_lost}, 0);

    // Clear coinciding with a qualified loss: the loss survives as count 1.
    bring_up();
    for (int k = 0; k < G + 2; k++) step(1, 0, 0);
    check("pre_coinc_cnt", {24'd0, loss_cnt}, 1);
    bring_up();
    for (int k = 0; k < G + 1; k++) step(1, 0, 0);
    check("pre_coinc_state", {30'd0, state}, 3);
    step(1, 0, 1);
    check("coinc_loss_cnt", {24'd0, loss_cnt}, 1);
    check("coinc_lock_lost", {31'd0, lock_lost}, 1);
    check("coinc_rst_out_n", {31'd0, rst_out_n}, 0);

    // Random lock runs with occasional clears and resets.
    begin
      logic lv;
      int   cyc;
      lv = 1'b0;
      cyc = 0;
      while (cyc < 5000) begin
        int len;
        len = $urandom_range(1, 40);
        lv = ~lv;
        for (int k = 0; k < len; k++) begin
          step(($urandom_range(0, 999) != 0), lv, ($urandom_range(0, 39) == 0));
          cyc++;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
